// File: rtl/result_streamer_pkg.sv
// Shared definitions for the result streamer: element/result widths,
// the streaming FSM state type and the FIFO entry layout.
//   ELEM_W   - width of one matrix element
//   ELEMS    - elements per result (2x2 matrix)
//   COUNT_W  - width of the result count / tag
//   RESULT_W - width of one packed result
package result_streamer_pkg;

  localparam int ELEM_W   = 6;
  localparam int ELEMS    = 4;
  localparam int COUNT_W  = 4;
  localparam int RESULT_W = ELEM_W * ELEMS;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // One stored result together with the count value it arrived with.
  typedef struct packed {
    logic [COUNT_W-1:0]  tag;
    logic [RESULT_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of whole results.
//   clock, reset  - rising-edge clock, asynchronous active-low reset
//   push, din     - write request and entry; accepted when not full, or when
//                   a pop happens on the same edge
//   pop, dout     - read request; dout always shows the oldest entry
//   full, empty   - occupancy == DEPTH / occupancy == 0
//   count         - occupancy, 0..DEPTH
module result_fifo
  import result_streamer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   din,
  output entry_t                   dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  entry_t         mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot the push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage carries no reset; only pointers and occupancy define contents.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_streamer.sv
// Captures each new multiplier result (signalled by a change of its result
// count) into a FIFO and streams it out one element per beat.
//   clock, reset        - rising-edge clock, asynchronous active-low reset
//   result_in           - packed result, element k = bits [6k+5:6k]
//   result_count        - multiplier result counter; any change = new result
//   out_ready           - downstream accepts the current beat
//   clear_overflow      - synchronous clear of the sticky overflow flag
//   out_valid/out_data/out_index/out_tag/out_last - output beat
//   fifo_full, fifo_empty - FIFO occupancy flags
//   overflow            - sticky: a result was dropped on a full FIFO
//   fsm_state           - current streaming FSM state (debug visibility)
// Handshake: a beat transfers on a rising edge where out_valid && out_ready;
// while out_valid && !out_ready every beat output holds stable.
module result_streamer
  import result_streamer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [RESULT_W-1:0] result_in,
  input  logic [COUNT_W-1:0]  result_count,
  input  logic                out_ready,
  input  logic                clear_overflow,
  output logic                out_valid,
  output logic [ELEM_W-1:0]   out_data,
  output logic [1:0]          out_index,
  output logic [COUNT_W-1:0]  out_tag,
  output logic                out_last,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic                overflow,
  output state_t              fsm_state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  state_t              state, next_state;
  logic [1:0]          index, next_index;
  entry_t              held;
  entry_t              fifo_dout;
  entry_t              fifo_din;
  logic [COUNT_W-1:0]  last_count;
  logic [AW:0]         occupancy;
  logic                change;
  logic                pop;
  logic                drop;

  assign change   = (result_count != last_count);
  assign fifo_din = '{tag: result_count, data: result_in};
  // Dropped only when already holding DEPTH entries and nothing leaves now.
  assign drop     = change && (occupancy == FULL_COUNT) && !pop;

  result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (change),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (occupancy)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      index      <= '0;
      held       <= '0;
      last_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state      <= next_state;
      index      <= next_index;
      last_count <= result_count;
      if (pop) held <= fifo_dout;
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Next-state: loading the next entry on the final beat keeps SEND busy
  // without a bubble between consecutive results.
  always_comb begin
    next_state = state;
    next_index = index;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          next_index = 2'd0;
          next_state = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (index != 2'd3) begin
            next_index = index + 2'd1;
          end else if (!fifo_empty) begin
            pop        = 1'b1;
            next_index = 2'd0;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Beat outputs are gated by SEND so reset clears them asynchronously.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_index = '0;
    out_tag   = '0;
    out_last  = 1'b0;
    if (state == SEND) begin
      out_valid = 1'b1;
      out_data  = held.data[index*ELEM_W +: ELEM_W];
      out_index = index;
      out_tag   = held.tag;
      out_last  = (index == 2'd3);
    end
  end

  assign fsm_state = state;

endmodule
